// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, the writeback/register-file
// stage and the ID-stage read ports.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
);
  logic [NREG-1:0]   Dselect_in;
  logic [DATA_W-1:0] daddrbus_in;
  logic [DATA_W-1:0] databus_in;
  logic              LW_in;
  logic              SW_in;
  logic [NREG-1:0]   Aselect;
  logic [NREG-1:0]   Bselect;
  logic [DATA_W-1:0] abus;
  logic [DATA_W-1:0] bbus;
  logic              sel_err;

  modport master (
    output Dselect_in, daddrbus_in, databus_in, LW_in, SW_in, Aselect, Bselect,
    input  abus, bbus, sel_err
  );

  modport slave (
    input  Dselect_in, daddrbus_in, databus_in, LW_in, SW_in, Aselect, Bselect,
    output abus, bbus, sel_err
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and one-hot addressed register file with two combinational
// read ports that bypass the value being written this cycle.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);
  localparam int IDX_W = $clog2(NREG);

  function automatic logic is_onehot(input logic [NREG-1:0] v);
    return (v != '0) && ((v & (v - NREG'(1))) == '0);
  endfunction

  function automatic logic is_multihot(input logic [NREG-1:0] v);
    return (v & (v - NREG'(1))) != '0;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_index(input logic [NREG-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (v[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  logic [DATA_W-1:0] wdata;
  logic              d_onehot;
  logic              we;
  logic [IDX_W-1:0]  widx;
  logic              sel_err_q;

  // r0 is hardwired to zero, so no storage is kept for it
  logic [DATA_W-1:0] regs [1:NREG-1];

  logic [NREG-1:0]   rd_sel  [2];
  logic [DATA_W-1:0] rd_data [2];

  assign wdata    = bus.LW_in ? bus.databus_in : bus.daddrbus_in;
  assign d_onehot = is_onehot(bus.Dselect_in);
  assign we       = ~bus.SW_in & d_onehot & ~bus.Dselect_in[0];
  assign widx     = onehot_index(bus.Dselect_in);

  // ---- commit edge: register file and sticky select error ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[widx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else if (!bus.SW_in && is_multihot(bus.Dselect_in)) begin
      sel_err_q <= 1'b1;
    end
  end

  // ---- combinational read ports with same-cycle write-through ----
  assign rd_sel[0] = bus.Aselect;
  assign rd_sel[1] = bus.Bselect;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      if (is_onehot(rd_sel[p]) && !rd_sel[p][0]) begin
        if (we && (rd_sel[p] == bus.Dselect_in)) begin
          rd_data[p] = wdata;
        end else begin
          for (int i = 1; i < NREG; i++) begin
            if (rd_sel[p][i]) rd_data[p] = regs[i];
          end
        end
      end
    end
  end

  assign bus.abus    = rd_data[0];
  assign bus.bbus    = rd_data[1];
  assign bus.sel_err = sel_err_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic against an array-based reference model of the register file.
module tb_wb_regfile;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [DATA_W-1:0] mregs [NREG];
  logic              merr;

  wb_regfile_if #(.DATA_W(DATA_W), .NREG(NREG)) bif ();

  wb_regfile #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int sel_index(input logic [NREG-1:0] s);
    int r;
    r = 0;
    for (int i = 0; i < NREG; i++) if (s[i]) r = i;
    return r;
  endfunction

  function automatic logic model_we();
    return !bif.SW_in && ($countones(bif.Dselect_in) == 1) && !bif.Dselect_in[0];
  endfunction

  function automatic logic [DATA_W-1:0] model_wdata();
    return bif.LW_in ? bif.databus_in : bif.daddrbus_in;
  endfunction

  function automatic logic [DATA_W-1:0] exp_read(input logic [NREG-1:0] s);
    if ($countones(s) != 1 || s[0]) return '0;
    if (model_we() && s == bif.Dselect_in) return model_wdata();
    return mregs[sel_index(s)];
  endfunction

  // Advance one clock: the model commits using the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NREG; i++) mregs[i] = '0;
      merr = 1'b0;
    end else begin
      if (!bif.SW_in && $countones(bif.Dselect_in) >= 2) merr = 1'b1;
      if (model_we()) mregs[sel_index(bif.Dselect_in)] = model_wdata();
    end
    #1;
  endtask

  task automatic idle_inputs();
    bif.Dselect_in  = '0;
    bif.daddrbus_in = '0;
    bif.databus_in  = '0;
    bif.LW_in       = 1'b0;
    bif.SW_in       = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bif.Aselect = 32'h1 << 5;
    bif.Bselect = 32'h1 << 31;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (bif.abus !== 32'h0) begin n_bad++; $display("FAIL reset_abus: got %h want %h", bif.abus, 32'h0); end
    n_cmp++; if (bif.bbus !== 32'h0) begin n_bad++; $display("FAIL reset_bbus: got %h want %h", bif.bbus, 32'h0); end
    n_cmp++; if (bif.sel_err !== 1'b0) begin n_bad++; $display("FAIL reset_sel_err: got %b want 0", bif.sel_err); end
  endtask

  task automatic test_alu_writeback();
    bif.Dselect_in  = 32'h1 << 7;
    bif.daddrbus_in = 32'h1234_5678;
    bif.databus_in  = 32'hDEAD_BEEF;
    bif.Aselect     = 32'h1 << 7;
    #1;
    n_cmp++; if (bif.abus !== 32'h1234_5678) begin n_bad++; $display("FAIL alu_bypass: got %h want %h", bif.abus, 32'h1234_5678); end
    tick();
    n_cmp++; if (bif.abus !== 32'h1234_5678) begin n_bad++; $display("FAIL alu_after_edge: got %h want %h", bif.abus, 32'h1234_5678); end
    idle_inputs();
    tick();
    #1;
    n_cmp++; if (bif.abus !== 32'h1234_5678) begin n_bad++; $display("FAIL alu_hold: got %h want %h", bif.abus, 32'h1234_5678); end
  endtask

  task automatic test_load_store();
    bif.LW_in      = 1'b1;
    bif.Dselect_in = 32'h1 << 3;
    bif.databus_in = 32'hCAFE_0001;
    bif.daddrbus_in = 32'h0000_0BAD;
    bif.Bselect    = 32'h1 << 3;
    tick();
    n_cmp++; if (bif.bbus !== 32'hCAFE_0001) begin n_bad++; $display("FAIL load_r3: got %h want %h", bif.bbus, 32'hCAFE_0001); end
    bif.LW_in       = 1'b0;
    bif.SW_in       = 1'b1;
    bif.daddrbus_in = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (bif.bbus !== 32'hCAFE_0001) begin n_bad++; $display("FAIL store_no_bypass: got %h want %h", bif.bbus, 32'hCAFE_0001); end
    tick();
    n_cmp++; if (bif.bbus !== 32'hCAFE_0001) begin n_bad++; $display("FAIL store_no_write: got %h want %h", bif.bbus, 32'hCAFE_0001); end
    // both flags set: store wins, nothing written
    bif.LW_in      = 1'b1;
    bif.databus_in = 32'h0BAD_0BAD;
    #1;
    n_cmp++; if (bif.bbus !== 32'hCAFE_0001) begin n_bad++; $display("FAIL sw_lw_bypass: got %h want %h", bif.bbus, 32'hCAFE_0001); end
    tick();
    n_cmp++; if (bif.bbus !== 32'hCAFE_0001) begin n_bad++; $display("FAIL sw_lw_no_write: got %h want %h", bif.bbus, 32'hCAFE_0001); end
    idle_inputs();
  endtask

  task automatic test_r0_bubble();
    bif.Dselect_in  = 32'h1;
    bif.daddrbus_in = 32'h55;
    bif.Aselect     = 32'h1;
    bif.Bselect     = 32'h1 << 7;
    #1;
    n_cmp++; if (bif.abus !== 32'h0) begin n_bad++; $display("FAIL r0_bypass: got %h want 0", bif.abus); end
    tick();
    n_cmp++; if (bif.abus !== 32'h0) begin n_bad++; $display("FAIL r0_write: got %h want 0", bif.abus); end
    bif.Dselect_in = '0;
    tick();
    n_cmp++; if (bif.bbus !== 32'h1234_5678) begin n_bad++; $display("FAIL bubble_r7: got %h want %h", bif.bbus, 32'h1234_5678); end
    n_cmp++; if (bif.sel_err !== 1'b0) begin n_bad++; $display("FAIL bubble_sel_err: got %b want 0", bif.sel_err); end
  endtask

  task automatic test_malformed();
    logic [DATA_W-1:0] r4, r9;
    r4 = mregs[4];
    r9 = mregs[9];
    bif.SW_in       = 1'b0;
    bif.Dselect_in  = (32'h1 << 4) | (32'h1 << 9);
    bif.daddrbus_in = 32'h77;
    bif.Aselect     = 32'h1 << 4;
    bif.Bselect     = 32'h1 << 9;
    #1;
    n_cmp++; if (bif.abus !== r4) begin n_bad++; $display("FAIL malformed_no_bypass: got %h want %h", bif.abus, r4); end
    n_cmp++; if (bif.sel_err !== 1'b0) begin n_bad++; $display("FAIL malformed_before_edge: got %b want 0", bif.sel_err); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (bif.abus !== r4) begin n_bad++; $display("FAIL malformed_r4: got %h want %h", bif.abus, r4); end
    n_cmp++; if (bif.bbus !== r9) begin n_bad++; $display("FAIL malformed_r9: got %h want %h", bif.bbus, r9); end
    n_cmp++; if (bif.sel_err !== 1'b1) begin n_bad++; $display("FAIL malformed_sel_err: got %b want 1", bif.sel_err); end
    for (int c = 0; c < 10; c++) begin
      bif.Dselect_in  = 32'h1 << (1 + c);
      bif.daddrbus_in = $urandom;
      tick();
      n_cmp++; if (bif.sel_err !== 1'b1) begin n_bad++; $display("FAIL sel_err_sticky[%0d]: got %b want 1", c, bif.sel_err); end
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (bif.sel_err !== 1'b0) begin n_bad++; $display("FAIL sel_err_clear: got %b want 0", bif.sel_err); end
  endtask

  task automatic test_reset_collision();
    bif.Dselect_in  = 32'h1 << 12;
    bif.daddrbus_in = 32'hA5A5_1212;
    tick();
    bif.daddrbus_in = 32'h0000_ABCD;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    bif.Aselect = 32'h1 << 12;
    #1;
    n_cmp++; if (bif.abus !== 32'h0) begin n_bad++; $display("FAIL collision_r12: got %h want 0", bif.abus); end
    bif.Aselect = (32'h1 << 1) | (32'h1 << 2);
    #1;
    n_cmp++; if (bif.abus !== 32'h0) begin n_bad++; $display("FAIL multi_read_sel: got %h want 0", bif.abus); end
  endtask

  function automatic logic [NREG-1:0] rand_sel();
    int k;
    k = $urandom_range(0, 11);
    if (k == 0) return '0;
    if (k == 1) return (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
    if (k == 2) return 32'h1;
    return 32'h1 << $urandom_range(1, 31);
  endfunction

  task automatic test_random();
    logic [DATA_W-1:0] ea, eb;
    for (int c = 0; c < 400; c++) begin
      reset           = ($urandom_range(0, 49) == 0);
      bif.Dselect_in  = rand_sel();
      bif.daddrbus_in = $urandom;
      bif.databus_in  = $urandom;
      bif.LW_in       = $urandom_range(0, 1);
      bif.SW_in       = ($urandom_range(0, 4) == 0);
      bif.Aselect     = ($urandom_range(0, 3) == 0) ? bif.Dselect_in : rand_sel();
      bif.Bselect     = ($urandom_range(0, 5) == 0) ? bif.Aselect : rand_sel();
      #1;
      ea = exp_read(bif.Aselect);
      eb = exp_read(bif.Bselect);
      n_cmp++; if (bif.abus !== ea) begin n_bad++; $display("FAIL rand_abus[%0d]: got %h want %h", c, bif.abus, ea); end
      n_cmp++; if (bif.bbus !== eb) begin n_bad++; $display("FAIL rand_bbus[%0d]: got %h want %h", c, bif.bbus, eb); end
      n_cmp++; if (bif.sel_err !== merr) begin n_bad++; $display("FAIL rand_sel_err[%0d]: got %b want %b", c, bif.sel_err, merr); end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    // sweep every register once through port A after the random traffic
    for (int r = 1; r < NREG; r++) begin
      bif.Aselect = 32'h1 << r;
      #1;
      n_cmp++; if (bif.abus !== mregs[r]) begin n_bad++; $display("FAIL sweep_r%0d: got %h want %h", r, bif.abus, mregs[r]); end
    end
  endtask

  initial begin
    reset = 1'b0;
    merr  = 1'b0;
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    idle_inputs();
    bif.Aselect = '0;
    bif.Bselect = '0;
    @(negedge clk);
    test_reset();
    test_alu_writeback();
    test_load_store();
    test_r0_bubble();
    test_malformed();
    test_reset_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage plus register file. Sits directly downstream of the MEM/WB pipeline register.
- Consumes the registered ALU result, the load data, the one-hot destination select, and the load/store flags. Selects the writeback value and commits it to a 32-entry register file on the clock edge.
- Provides two one-hot-addressed read ports with same-cycle write-through bypass to the ID stage.

Parameters:
DATA_W, 32, register and bus width in bits
NREG, 32, number of registers; also the width of every one-hot select bus (fixed at 32 for this core)

Ports:
clk  input  1  pipeline clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk
Dselect_in  input  NREG  one-hot destination register select from MEM/WB
daddrbus_in  input  DATA_W  ALU result / address from MEM/WB
databus_in  input  DATA_W  data-memory load data from MEM/WB
LW_in  input  1  load flag: writeback value = databus_in
SW_in  input  1  store flag: no register write this cycle
Aselect  input  NREG  one-hot read select, port A
Bselect  input  NREG  one-hot read select, port B
abus  output  DATA_W  read data, port A
bbus  output  DATA_W  read data, port B
sel_err  output  1  sticky error: a malformed destination select was presented

Behaviour:
- Storage: regs[0..NREG-1], DATA_W bits each.
- regs[0] reads as 0 and is never written.

Writeback value and write enable:
- wdata = LW_in ? databus_in : daddrbus_in.
- d_onehot = exactly one bit of Dselect_in set.
- we = ~SW_in & d_onehot & ~Dselect_in[0].
- On the rising clk edge with reset=0 and we=1: regs[i] <= wdata, where i is the set bit of Dselect_in.
- Dselect_in all zero means no write (bubble); this is not an error.

sel_err:
- On the rising edge with reset=0, SW_in=0, and Dselect_in having two or more bits set: sel_err <= 1 and no register is written.
- Once set, sel_err stays 1 until reset.
- SW_in=1 masks the check.

Reset:
- Synchronous. On a rising edge with reset=1, all regs <= 0 and sel_err <= 0.
- Reset takes priority over a simultaneous write; the write is lost.
- Consequently abus, bbus and sel_err read 0 after the first reset edge.
- Reset asserted mid-stream has no effect until that edge. Outputs before the first reset edge are undefined.

Read ports (combinational, zero latency; identical rules for A and B):
- Select not one-hot (zero bits or two or more bits set): bus = 0.
- Select bit 0 set: bus = 0.
- Select equals Dselect_in and we=1: bus = wdata (write-through bypass, same cycle, before the edge).
- Otherwise: bus = the selected register.
- A and B may select the same register; both show the same value.

Latency and ordering:
- Write becomes architecturally visible in the same cycle through the bypass, and via storage from the next cycle.
- SW_in and LW_in both set: SW_in wins, so no write.

Test Plan:
- Reset then read: assert reset for one edge, Aselect=1<<5, Bselect=1<<31 -> abus=0, bbus=0, sel_err=0.
- ALU writeback: Dselect_in=1<<7, daddrbus_in=32'h1234_5678, databus_in=32'hDEAD_BEEF, LW_in=0, SW_in=0, with Aselect=1<<7 -> abus=32'h1234_5678 in the same cycle (bypass) and after the edge. Then deassert and hold Aselect -> abus stays 32'h1234_5678.
- Load and store suppression: LW_in=1, Dselect_in=1<<3, databus_in=32'hCAFE_0001 -> r3=32'hCAFE_0001. Next cycle SW_in=1, Dselect_in=1<<3, daddrbus_in=32'hFFFF_FFFF -> r3 unchanged and no bypass (bbus with Bselect=1<<3 reads 32'hCAFE_0001).
- r0 and bubble: Dselect_in=1 with daddrbus_in=32'h55 -> abus with Aselect=1 reads 0. Dselect_in=0 -> no register changes and sel_err=0.
- Malformed select: SW_in=0, Dselect_in=(1<<4)|(1<<9), daddrbus_in=32'h77 -> r4 and r9 unchanged, sel_err=1 from the next edge and stays 1 for 10 further clean cycles. A reset edge clears it to 0.
- Reset versus write collision: reset=1 and a valid write to r12 on the same edge -> r12=0 afterwards. Aselect=(1<<1)|(1<<2) -> abus=0.
